// File: rtl/fir_mc.sv
// Multi-channel time-multiplexed fixed-point FIR with one shared MAC; FIR_MC_SAT_EN selects saturating (else wrapping) output.
// Latency: next to ready is TAPS+2 cycles; one sample every TAPS+3 cycles, channels interleaved round-robin.
// Backpressure: none on the output (ready is a pulse); the source is paced by next, and stop parks the filter in DONE.
module fir_mc #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int TAPS   = 8,
    parameter int CH     = 2,
    parameter int SHIFT  = 15,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1,
    localparam int TAP_W = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     stop,
    input  logic signed [DATA_W-1:0] in,
    output logic                     next,
    output logic                     ready,
    output logic signed [OUT_W-1:0]  out,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     coef_we,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     busy,
    output logic                     done
);

    localparam int ACC_W  = DATA_W + COEF_W + TAP_W;
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W:0] RND_C   = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
`ifdef FIR_MC_SAT_EN
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        MAC  = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                   state;
    logic [CH_W-1:0]          ch;
    logic [TAP_W-1:0]         tap;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] dl   [CH][TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W:0]    rnd;
    logic signed [OUT_W-1:0]  q;
`ifdef FIR_MC_SAT_EN
    logic signed [ACC_W:0]    r;
`endif

    // One product per MAC cycle; the rounded result is taken from the final partial sum.
    always_comb begin
        prod = PROD_W'(dl[ch][tap]) * PROD_W'(coef[tap]);
        sum  = acc + ACC_W'(prod);
        rnd  = {sum[ACC_W-1], sum} + RND_C;
`ifdef FIR_MC_SAT_EN
        r = rnd >>> SHIFT;
        if (r > OUT_MAX)
            q = OUT_MAX[OUT_W-1:0];
        else if (r < OUT_MIN)
            q = OUT_MIN[OUT_W-1:0];
        else
            q = r[OUT_W-1:0];
`else
        q = OUT_W'(rnd >>> SHIFT);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            next   <= 1'b0;
            ready  <= 1'b0;
            out    <= '0;
            out_ch <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ch     <= '0;
            tap    <= '0;
            acc    <= '0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < TAPS; k++)
                    dl[c][k] <= '0;
            for (int k = 0; k < TAPS; k++)
                coef[k] <= '0;
        end else begin
            next  <= 1'b0;
            ready <= 1'b0;

            // Coefficients may only change while no sample is in flight.
            if (coef_we && (state == IDLE || state == DONE) && int'(coef_addr) < TAPS)
                coef[coef_addr] <= coef_wdata;

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= REQ;
                        next  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dl[ch][0] <= in;
                        for (int k = 1; k < TAPS; k++)
                            dl[ch][k] <= dl[ch][k-1];
                        tap   <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (tap == TAP_W'(TAPS - 1)) begin
                        state  <= OUT;
                        ready  <= 1'b1;
                        out    <= q;
                        out_ch <= ch;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                OUT: begin
                    ch    <= (ch == CH_W'(CH - 1)) ? '0 : ch + 1'b1;
                    state <= REQ;
                    next  <= 1'b1;
                end
                DONE: begin
                    if (!stop && en) begin
                        state <= REQ;
                        next  <= 1'b1;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mc.sv
// Directed bench for fir_mc: table-driven sample/expectation records plus hand sequences for stop, reset and write corners.
`timescale 1ns/1ps
module tb_fir_mc;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               stop = 1'b0;
    logic signed [15:0] in = '0;
    logic               next, ready, busy, done;
    logic signed [15:0] out;
    logic               out_ch;
    logic               coef_we = 1'b0;
    logic [2:0]         coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;

    fir_mc #(
        .DATA_W(16), .COEF_W(16), .OUT_W(16), .TAPS(8), .CH(2), .SHIFT(15)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .stop(stop), .in(in),
        .next(next), .ready(ready), .out(out), .out_ch(out_ch),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef FIR_MC_SAT_EN
    localparam logic signed [15:0] OVF_EXP = 16'sh7FFF;
`else
    localparam logic signed [15:0] OVF_EXP = 16'shFFF0;
`endif

    typedef struct {
        int                 phase;
        logic signed [15:0] din;
        bit                 chk;
        logic signed [15:0] exp_out;
        int                 exp_ch;
    } vec_t;

    vec_t vt[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   ready_cnt = 0;
    int   cyc = 0;
    int   last_next = -1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ready) ready_cnt <= ready_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int p, input int d, input bit c, input int e, input int ch);
        vt.push_back('{phase: p, din: 16'(d), chk: c, exp_out: 16'(e), exp_ch: ch});
    endtask

    task automatic wr_coef(input int a, input int v);
        coef_we = 1'b1; coef_addr = 3'(a); coef_wdata = 16'(v);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; stop = 1'b0; coef_we = 1'b0; in = '0;
        @(negedge clk);
        rst = 1'b1; last_next = -1;
    endtask

    // Serve one request: drive x after next, optionally poke a coefficient write mid-MAC, return the result.
    task automatic do_sample(input logic signed [15:0] x, input int we_at,
                             output logic signed [15:0] y, output int ych,
                             output int lat, output int gap);
        int w;
        w = 0;
        y = '0; ych = -1; lat = -1; gap = -1;
        while (!next && w < 40) begin @(negedge clk); w++; end
        if (!next) begin
            check("next_timeout", 0, 1);
            return;
        end
        gap = (last_next < 0) ? -1 : cyc - last_next;
        last_next = cyc;
        in = x;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == we_at) begin
                coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'sh4000;
            end else begin
                coef_we = 1'b0;
            end
        end while (!ready && lat < 40);
        if (!ready) check("ready_timeout", 0, 1);
        y = out;
        ych = int'(out_ch);
    endtask

    task automatic run_phase(input int p);
        logic signed [15:0] y;
        int ych, lat, gap;
        foreach (vt[i]) begin
            if (vt[i].phase == p) begin
                do_sample(vt[i].din, -1, y, ych, lat, gap);
                if (vt[i].chk) begin
                    check($sformatf("p%0d_out[%0d]", p, i), y, vt[i].exp_out);
                    check($sformatf("p%0d_ch[%0d]", p, i), ych, vt[i].exp_ch);
                end
                if (p == 1) begin
                    check($sformatf("next_to_ready[%0d]", i), lat, 10);
                    if (gap >= 0) check($sformatf("next_to_next[%0d]", i), gap, 11);
                end
            end
        end
    endtask

    initial begin
        logic signed [15:0] y;
        int ych, lat, gap, w, nh, rh, rc0;

        // Impulse: 0x8000 in tap 7 is -32768 signed, so the 8th ch0 output is negative.
        for (int n = 0; n < 16; n++)
            add(1, (n == 0) ? 16'h4000 : 0, 1'b1,
                (n % 2 == 1) ? 0 : ((n == 14) ? -16384 : 2048 * (n / 2 + 1)), n % 2);
        for (int n = 0; n < 16; n++)
            add(2, 16'h7FFF, n >= 14, OVF_EXP, n % 2);
        add(3,  16384, 1'b1,  1, 0);
        add(3,  16383, 1'b1,  0, 1);
        add(3, -16384, 1'b1,  0, 0);
        add(3, -16385, 1'b1, -1, 1);
        add(3,  32767, 1'b1,  1, 0);
        add(3, -32768, 1'b1, -1, 1);
        add(4, 16'h0100, 1'b1,  32, 0);
        add(4, 16'h0200, 1'b1,  64, 1);
        add(4, 16'h0300, 1'b1, 160, 0);
        add(4, 16'h0400, 1'b1, 256, 1);

        #1 rst = 1'b0;
        #11;
        check("rst_next", next, 0);
        check("rst_ready", ready, 0);
        check("rst_out", out, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_next", next, 0);

        rc0 = ready_cnt;
        for (int k = 0; k < 8; k++) wr_coef(k, 4096 * (k + 1));
        en = 1'b1;
        run_phase(1);
        #1 check("ready_pulses", ready_cnt - rc0, 16);

        do_reset();
        for (int k = 0; k < 8; k++) wr_coef(k, 16'h7FFF);
        en = 1'b1;
        run_phase(2);

        do_reset();
        wr_coef(0, 1);
        en = 1'b1;
        run_phase(3);
        do_sample(16'sd16384, 4, y, ych, lat, gap);
        check("wr_ignored_out", y, 1);
        check("wr_ignored_ch", ych, 0);
        do_sample(16'sd16384, -1, y, ych, lat, gap);
        check("wr_ignored_after", y, 1);

        do_reset();
        rc0 = ready_cnt;
        for (int k = 0; k < 8; k++) wr_coef(k, 4096 * (k + 1));
        en = 1'b1;
        run_phase(4);
        w = 0;
        while (!next && w < 40) begin @(negedge clk); w++; end
        check("stop_req_seen", next, 1);
        stop = 1'b1;
        repeat (3) @(negedge clk);
        check("stop_done", done, 1);
        check("stop_busy", busy, 0);
        nh = 0; rh = 0;
        repeat (20) begin
            @(negedge clk);
            nh += int'(next);
            rh += int'(ready);
        end
        check("stop_next_quiet", nh, 0);
        check("stop_ready_quiet", rh, 0);
        check("stop_outputs", ready_cnt - rc0, 4);
        stop = 1'b0;
        do_sample(16'sh0500, -1, y, ych, lat, gap);
        check("resume_out", y, 448);
        check("resume_ch", ych, 0);
        check("resume_done", done, 0);

        w = 0;
        while (!next && w < 40) begin @(negedge clk); w++; end
        check("rmm_req_seen", next, 1);
        in = 16'sh0100;
        repeat (4) @(negedge clk);
        check("rmm_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("rmm_next", next, 0);
        check("rmm_ready", ready, 0);
        check("rmm_busy", busy, 0);
        check("rmm_out", out, 0);
        check("rmm_done", done, 0);
        @(negedge clk);
        rst = 1'b1; last_next = -1;
        do_sample(16'sh1234, -1, y, ych, lat, gap);
        check("rmm_first_out", y, 0);
        check("rmm_first_ch", ych, 0);
        check("rmm_first_lat", lat, 10);

        do_reset();
        en = 1'b1; coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'sh2000;
        @(negedge clk);
        coef_we = 1'b0;
        do_sample(16'sh0100, -1, y, ych, lat, gap);
        check("edge_write_out", y, 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
